accelerator_multihead_controller: RTL and testbench

ACCELERATOR_MULTIHEAD_CONTROLLER -- requirements
Module: accelerator_multihead_controller

---
 rtl/accelerator_multihead_controller.sv | 177 +++++++++++++++++
 tb/tb_accelerator_multihead_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accelerator_multihead_controller.sv
// Multi-head accumulate controller.
//
// For each of HEADS heads, for each (i, l) pair, the block accepts K
// element/weight beats, accumulates DATA_IN*W_IN (unsigned, wrapping at
// DATA_SIZE bits) and presents the sum on a valid/ready output together with
// the head index. The loop bounds I, L and K are latched when START is
// accepted in IDLE, so the SIZE_* inputs may change freely during a run.
//
// Ports
//   CLK, RST                  clock, asynchronous active-low reset
//   START / READY             run request / block idle
//   SIZE_I_IN/L_IN/K_IN       loop bounds, latched on accepted START
//   DATA_IN_VALID/READY       input beat handshake; DATA_IN, W_IN paired per beat
//   DATA_OUT_VALID/READY      result handshake; DATA_OUT = sum, HEAD_OUT = head
//   I/L/K_ENABLE              one-cycle progress strobes, registered
module accelerator_multihead_controller #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int HEADS        = 4
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic                                     START,
  output logic                                     READY,
  input  logic [DATA_SIZE-1:0]                     SIZE_I_IN,
  input  logic [DATA_SIZE-1:0]                     SIZE_L_IN,
  input  logic [DATA_SIZE-1:0]                     SIZE_K_IN,
  input  logic                                     DATA_IN_VALID,
  output logic                                     DATA_IN_READY,
  input  logic [DATA_SIZE-1:0]                     DATA_IN,
  input  logic [DATA_SIZE-1:0]                     W_IN,
  output logic                                     DATA_OUT_VALID,
  input  logic                                     DATA_OUT_READY,
  output logic [DATA_SIZE-1:0]                     DATA_OUT,
  output logic [(HEADS > 1 ? $clog2(HEADS) : 1)-1:0] HEAD_OUT,
  output logic                                     I_ENABLE,
  output logic                                     L_ENABLE,
  output logic                                     K_ENABLE
);

  localparam int HW = (HEADS > 1) ? $clog2(HEADS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    INPUT  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t state, next_state;

  logic [DATA_SIZE-1:0]    size_i, size_l, size_k;
  logic [CONTROL_SIZE-1:0] cnt_i, cnt_l, cnt_k;
  logic [HW-1:0]           cnt_h;
  logic [DATA_SIZE-1:0]    acc;
  logic                    k_en, l_en, i_en;

  logic beat, out_hs;
  logic k_last, l_last, i_last, h_last;
  logic size_zero;

  assign beat   = (state == INPUT) && DATA_IN_VALID;
  assign out_hs = (state == OUTPUT) && DATA_OUT_READY;

  // Counters are compared in the size domain so CONTROL_SIZE and DATA_SIZE
  // may differ.
  assign k_last = (DATA_SIZE'(cnt_k) == (size_k - DATA_SIZE'(1)));
  assign l_last = (DATA_SIZE'(cnt_l) == (size_l - DATA_SIZE'(1)));
  assign i_last = (DATA_SIZE'(cnt_i) == (size_i - DATA_SIZE'(1)));
  assign h_last = (cnt_h == HW'(HEADS - 1));

  assign size_zero = (size_i == '0) || (size_l == '0) || (size_k == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    READY          = 1'b0;
    DATA_IN_READY  = 1'b0;
    DATA_OUT_VALID = 1'b0;
    case (state)
      IDLE: begin
        READY = 1'b1;
        if (START) next_state = LOAD;
      end
      LOAD: begin
        next_state = size_zero ? IDLE : INPUT;
      end
      INPUT: begin
        DATA_IN_READY = 1'b1;
        if (beat && k_last) next_state = OUTPUT;
      end
      OUTPUT: begin
        DATA_OUT_VALID = 1'b1;
        if (DATA_OUT_READY) begin
          next_state = (l_last && i_last && h_last) ? IDLE : INPUT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      size_i <= '0;
      size_l <= '0;
      size_k <= '0;
      cnt_i  <= '0;
      cnt_l  <= '0;
      cnt_k  <= '0;
      cnt_h  <= '0;
      acc    <= '0;
      k_en   <= 1'b0;
      l_en   <= 1'b0;
      i_en   <= 1'b0;
    end else begin
      k_en <= 1'b0;
      l_en <= 1'b0;
      i_en <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            size_i <= SIZE_I_IN;
            size_l <= SIZE_L_IN;
            size_k <= SIZE_K_IN;
            cnt_i  <= '0;
            cnt_l  <= '0;
            cnt_k  <= '0;
            cnt_h  <= '0;
            acc    <= '0;
          end
        end
        INPUT: begin
          if (beat) begin
            acc  <= acc + (DATA_IN * W_IN);
            k_en <= 1'b1;
            if (k_last) cnt_k <= '0;
            else        cnt_k <= cnt_k + CONTROL_SIZE'(1);
          end
        end
        OUTPUT: begin
          if (out_hs) begin
            acc  <= '0;
            l_en <= 1'b1;
            if (l_last) begin
              cnt_l <= '0;
              i_en  <= 1'b1;
              if (i_last) begin
                cnt_i <= '0;
                if (h_last) cnt_h <= '0;
                else        cnt_h <= cnt_h + HW'(1);
              end else begin
                cnt_i <= cnt_i + CONTROL_SIZE'(1);
              end
            end else begin
              cnt_l <= cnt_l + CONTROL_SIZE'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign DATA_OUT = acc;
  assign HEAD_OUT = cnt_h;
  assign K_ENABLE = k_en;
  assign L_ENABLE = l_en;
  assign I_ENABLE = i_en;

endmodule

// File: tb/tb_accelerator_multihead_controller.sv
// Scoreboard bench for accelerator_multihead_controller (DATA_SIZE=8, HEADS=2).
// Directed runs push hand-computed {head, sum} pairs into queues; a monitor
// pops and compares on every result handshake.
module tb_accelerator_multihead_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       START = 1'b0;
  logic       READY;
  logic [7:0] SIZE_I_IN = '0, SIZE_L_IN = '0, SIZE_K_IN = '0;
  logic       DATA_IN_VALID = 1'b0;
  logic       DATA_IN_READY;
  logic [7:0] DATA_IN = '0, W_IN = '0;
  logic       DATA_OUT_VALID;
  logic       DATA_OUT_READY = 1'b0;
  logic [7:0] DATA_OUT;
  logic       HEAD_OUT;
  logic       I_ENABLE, L_ENABLE, K_ENABLE;

  accelerator_multihead_controller #(
    .DATA_SIZE(8),
    .CONTROL_SIZE(8),
    .HEADS(2)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .SIZE_I_IN(SIZE_I_IN), .SIZE_L_IN(SIZE_L_IN), .SIZE_K_IN(SIZE_K_IN),
    .DATA_IN_VALID(DATA_IN_VALID), .DATA_IN_READY(DATA_IN_READY),
    .DATA_IN(DATA_IN), .W_IN(W_IN),
    .DATA_OUT_VALID(DATA_OUT_VALID), .DATA_OUT_READY(DATA_OUT_READY),
    .DATA_OUT(DATA_OUT), .HEAD_OUT(HEAD_OUT),
    .I_ENABLE(I_ENABLE), .L_ENABLE(L_ENABLE), .K_ENABLE(K_ENABLE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int qh[$];
  int qd[$];
  int kc = 0, lc = 0, ic = 0, vc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int h, input int d);
    qh.push_back(h);
    qd.push_back(d);
  endtask

  // Monitor: the handshake completes on the following rising edge.
  always @(negedge CLK) begin
    if (RST === 1'b1 && DATA_OUT_VALID === 1'b1 && DATA_OUT_READY === 1'b1) begin
      if (qd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got head %0d data %0d, none expected", HEAD_OUT, DATA_OUT);
      end else begin
        int eh, ed;
        eh = qh.pop_front();
        ed = qd.pop_front();
        check("head_out", 64'(HEAD_OUT), 64'(eh));
        check("data_out", 64'(DATA_OUT), 64'(ed));
      end
    end
  end

  always @(negedge CLK) begin
    if (K_ENABLE === 1'b1) kc++;
    if (L_ENABLE === 1'b1) lc++;
    if (I_ENABLE === 1'b1) ic++;
    if (DATA_OUT_VALID === 1'b1) vc++;
  end

  // Called at posedge+1; returns at posedge+1 of the edge that latched START.
  task automatic start_run(input logic [7:0] si, input logic [7:0] sl, input logic [7:0] sk);
    SIZE_I_IN = si;
    SIZE_L_IN = sl;
    SIZE_K_IN = sk;
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  // Called at posedge+1; waits counts negedges with DATA_IN_READY low.
  task automatic send_beat(input logic [7:0] d, input logic [7:0] w, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    DATA_IN = d;
    W_IN = w;
    DATA_IN_VALID = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (DATA_IN_READY === 1'b1) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: DATA_IN_READY stayed %0d, required 1", DATA_IN_READY);
    end
    @(posedge CLK);
    #1 DATA_IN_VALID = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic [7:0] w);
    int wt;
    send_beat(d, w, wt);
  endtask

  task automatic drain;
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (READY === 1'b1 && qd.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done", 64'(done), 64'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_counts;
    kc = 0; lc = 0; ic = 0; vc = 0;
  endtask

  initial begin
    int wt;

    // Reset state
    #2;
    check("rst_ready", 64'(READY), 64'd1);
    check("rst_in_ready", 64'(DATA_IN_READY), 64'd0);
    check("rst_out_valid", 64'(DATA_OUT_VALID), 64'd0);
    check("rst_data_out", 64'(DATA_OUT), 64'd0);
    check("rst_head_out", 64'(HEAD_OUT), 64'd0);
    check("rst_strobes", 64'({I_ENABLE, L_ENABLE, K_ENABLE}), 64'd0);
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1;

    // I=1, L=2, K=3: four sums of 2*(1+2+3)=12, heads 0,0,1,1
    clear_counts();
    DATA_OUT_READY = 1'b1;
    push(0, 12); push(0, 12); push(1, 12); push(1, 12);
    start_run(8'd1, 8'd2, 8'd3);
    send_beat(8'd1, 8'd2, wt);
    check("start_to_beat_waits", 64'(wt), 64'd1);
    beat(8'd2, 8'd2);
    beat(8'd3, 8'd2);
    @(negedge CLK);
    check("last_beat_to_valid", 64'(DATA_OUT_VALID), 64'd1);
    check("in_ready_in_output", 64'(DATA_IN_READY), 64'd0);
    @(posedge CLK);
    #1;
    for (int r = 1; r < 4; r++) begin
      beat(8'd1, 8'd2);
      beat(8'd2, 8'd2);
      beat(8'd3, 8'd2);
    end
    drain();
    check("t1_k_pulses", 64'(kc), 64'd12);
    check("t1_l_pulses", 64'(lc), 64'd4);
    check("t1_i_pulses", 64'(ic), 64'd2);

    // K=1 with output back-pressure for 5 cycles
    clear_counts();
    DATA_OUT_READY = 1'b0;
    push(0, 15); push(1, 16);
    start_run(8'd1, 8'd1, 8'd1);
    beat(8'd5, 8'd3);
    for (int n = 0; n < 5; n++) begin
      @(negedge CLK);
      check("hold_valid", 64'(DATA_OUT_VALID), 64'd1);
      check("hold_data", 64'(DATA_OUT), 64'd15);
      check("hold_in_ready", 64'(DATA_IN_READY), 64'd0);
    end
    @(posedge CLK);
    #1 DATA_OUT_READY = 1'b1;
    beat(8'd4, 8'd4);
    drain();

    // SIZE_K_IN=0: LOAD then straight back to IDLE, nothing emitted
    clear_counts();
    start_run(8'd1, 8'd1, 8'd0);
    @(negedge CLK);
    check("k0_ready_in_load", 64'(READY), 64'd0);
    @(negedge CLK);
    check("k0_ready_back", 64'(READY), 64'd1);
    repeat (4) @(negedge CLK);
    check("k0_no_valid", 64'(vc), 64'd0);
    check("k0_no_strobes", 64'(kc + lc + ic), 64'd0);
    @(posedge CLK);
    #1;

    // 8-bit wrap: 16*16 + 16*16 = 512 -> 0
    push(0, 0); push(1, 0);
    start_run(8'd1, 8'd1, 8'd2);
    beat(8'd16, 8'd16);
    beat(8'd16, 8'd16);
    beat(8'd16, 8'd16);
    beat(8'd16, 8'd16);
    drain();

    // Reset during INPUT, then a fresh run
    start_run(8'd1, 8'd1, 8'd3);
    beat(8'd9, 8'd9);
    #2 RST = 1'b0;
    #1;
    check("midrst_ready", 64'(READY), 64'd1);
    check("midrst_out_valid", 64'(DATA_OUT_VALID), 64'd0);
    check("midrst_in_ready", 64'(DATA_IN_READY), 64'd0);
    @(posedge CLK);
    #1 RST = 1'b1;
    push(0, 21); push(1, 10);
    start_run(8'd1, 8'd1, 8'd1);
    @(negedge CLK);
    check("post_rst_start_taken", 64'(READY), 64'd0);
    @(posedge CLK);
    #1;
    beat(8'd7, 8'd3);
    beat(8'd2, 8'd5);
    drain();

    // START and new sizes during OUTPUT are ignored
    clear_counts();
    DATA_OUT_READY = 1'b0;
    push(0, 3); push(0, 6); push(1, 9); push(1, 12);
    start_run(8'd1, 8'd2, 8'd1);
    beat(8'd1, 8'd3);
    SIZE_I_IN = 8'd2;
    SIZE_L_IN = 8'd3;
    SIZE_K_IN = 8'd2;
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    DATA_OUT_READY = 1'b1;
    beat(8'd2, 8'd3);
    beat(8'd3, 8'd3);
    beat(8'd4, 8'd3);
    drain();
    check("t6_k_pulses", 64'(kc), 64'd4);
    check("t6_l_pulses", 64'(lc), 64'd4);
    vc = 0;
    repeat (5) @(negedge CLK);
    check("t6_no_extra_valid", 64'(vc), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
